// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle datapath controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REG  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       lord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_src_a;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  // States that wait on mem_ready and are covered by the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, every mux/enable out.
interface multicycle_ctrl_fsm_if;
  import ctrl_pkg::*;

  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, lorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB, ALUSrcA;
  logic       RegWrite, RegDst, retire, trap;
  state_t     state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, lorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, retire, trap, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, lorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, retire, trap, state
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Wait-state counter for memory states; flags expiry when mem_ready never came.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic mem_ready,
  output logic expired
);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] cnt;

  // Saturates so a disabled timeout never wraps back through LIMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (enable && cnt != '1) cnt <= cnt + TW'(1);
  end

  assign expired = (TIMEOUT != 0) && (cnt == LIMIT) && !mem_ready;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore controller for the shared-memory multicycle RV32 datapath.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 16,
  parameter int TW            = 5
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);
  state_t st, nxt;
  logic   rdy, expired, trap_q;
  ctrl_t  c;

  assign rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  ctrl_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (nxt != st),
    .enable   (is_mem_state(st)),
    .mem_ready(rdy),
    .expired  (expired)
  );

  always_comb begin
    nxt = st;
    case (st)
      FETCH:    if (rdy) nxt = DECODE;   else if (expired) nxt = TRAP;
      DECODE: begin
        case (bus.opcode)
          OP_R:               nxt = EXEC_R;
          OP_I:               nxt = EXEC_I;
          OP_LOAD, OP_STORE:  nxt = MEMADR;
          OP_BRANCH:          nxt = BRANCH;
          OP_JAL:             nxt = JAL;
          OP_JALR:            nxt = JALR;
          OP_LUI:             nxt = LUI;
          default:            nxt = TRAP;
        endcase
      end
      MEMADR:   nxt = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (rdy) nxt = MEMWB;    else if (expired) nxt = TRAP;
      MEMWRITE: if (rdy) nxt = FETCH;    else if (expired) nxt = TRAP;
      EXEC_R, EXEC_I, LUI:              nxt = ALUWB;
      ALUWB, MEMWB, BRANCH, JAL, JALR:  nxt = FETCH;
      TRAP:     nxt = TRAP;
      default:  nxt = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= FETCH;
      trap_q <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt == TRAP) trap_q <= 1'b1;
    end
  end

  // Only FETCH looks at mem_ready; every other control is a pure state decode.
  always_comb begin
    c = '0;
    case (st)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.alu_src_a = SRCA_PC;
        c.pc_source = PCS_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_BIMM;
        c.alu_src_a = SRCA_PC;
        c.alu_op    = ALU_ADD;
      end
      MEMADR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      MEMREAD: begin
        c.lord     = 1'b1;
        c.mem_read = 1'b1;
      end
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.lord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
        c.alu_op        = ALU_SUB;
        c.alu_src_a     = SRCA_REG;
        c.alu_src_b     = SRCB_REG;
      end
      JAL: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
      end
      JALR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_ALU;
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_PASSB;
      end
      default: c = '0;
    endcase
  end

  assign bus.PCWrite     = c.pc_write;
  assign bus.PCWriteCond = c.pc_write_cond;
  assign bus.lorD        = c.lord;
  assign bus.MemRead     = c.mem_read;
  assign bus.MemWrite    = c.mem_write;
  assign bus.IRWrite     = c.ir_write;
  assign bus.MemtoReg    = c.mem_to_reg;
  assign bus.PCSource    = c.pc_source;
  assign bus.ALUOp       = c.alu_op;
  assign bus.ALUSrcB     = c.alu_src_b;
  assign bus.ALUSrcA     = c.alu_src_a;
  assign bus.RegWrite    = c.reg_write;
  assign bus.RegDst      = c.reg_dst;
  assign bus.state       = st;
  assign bus.trap        = trap_q;
  assign bus.retire      = (st == ALUWB) || (st == MEMWB) || (st == BRANCH) ||
                           (st == JAL) || (st == JALR) || ((st == MEMWRITE) && rdy);
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Parametrised successor of the multicycle datapath controller. It is a Moore-style FSM that decodes the 7-bit RV32 opcode and sequences the shared-memory multicycle datapath. It adds I-type ALU, JAL, JALR and LUI support, a memory ready/wait handshake, a wait-state timeout, an illegal-opcode trap and a retire pulse. It sits beside the datapath and drives every mux and enable in it.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH, MEMREAD and MEMWRITE wait for mem_ready; 0 = mem_ready ignored (single-cycle memory).
TIMEOUT, 16, maximum wait cycles in a memory state before trapping; 0 disables the timeout.
TW, 5, width of the wait counter; must satisfy 2^TW > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  7  instruction[6:0], valid from DECODE onward
mem_ready  in  1  memory completed the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
lorD  out  1  memory address = ALUOut (1) or PC (0)
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  writeback from MDR (1) or ALUOut (0)
PCSource  out  2  00 ALU result, 01 ALUOut, 10 PC+imm jump target
ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 pass-B
ALUSrcB  out  2  00 regB, 01 const 4, 10 imm, 11 branch imm
ALUSrcA  out  2  00 PC, 01 regA, 10 zero
RegWrite  out  1  register file write
RegDst  out  1  write rd from R/I ALU path
retire  out  1  one-cycle pulse when an instruction completes
trap  out  1  sticky: illegal opcode or timeout; cleared only by reset
state  out  4  current state, for debug

Behaviour:
- Reset (reset = 0, asynchronous): state = FETCH, wait counter = 0, trap = 0, retire = 0. All other outputs take their FETCH values.
- Outputs are decoded from the state register only. The one exception is gating by mem_ready: in FETCH, PCWrite and IRWrite are asserted only when mem_ready is 1 (or MEM_HANDSHAKE = 0).
- State encodings and control values:
  - FETCH: MemRead, IRWrite*, PCWrite*, ALUSrcB = 01, ALUOp = 00, ALUSrcA = 00, PCSource = 00. (*gated by mem_ready)
  - DECODE: ALUSrcB = 11, ALUSrcA = 00, ALUOp = 00.
  - MEMADR: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00.
  - MEMREAD: lorD, MemRead.
  - MEMWB: MemtoReg, RegWrite.
  - MEMWRITE: lorD, MemWrite.
  - EXEC_R: ALUSrcA = 01, ALUSrcB = 00, ALUOp = 10.
  - EXEC_I: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 10.
  - ALUWB: RegWrite, RegDst.
  - BRANCH: PCWriteCond, PCSource = 01, ALUOp = 01, ALUSrcA = 01, ALUSrcB = 00.
  - JAL: PCWrite, PCSource = 10, RegWrite, RegDst, ALUSrcA = 00, ALUSrcB = 01.
  - JALR: PCWrite, PCSource = 00, ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, RegWrite, RegDst.
  - LUI: ALUSrcA = 10, ALUSrcB = 10, ALUOp = 11. Next state is ALUWB.
  - TRAP: all controls 0; the FSM holds here until reset.
- Transitions:
  - FETCH → DECODE on mem_ready; otherwise stay.
  - DECODE dispatches on opcode: 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEMADR; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; any other opcode → TRAP with trap = 1.
  - EXEC_R and EXEC_I → ALUWB.
  - MEMADR → MEMREAD if opcode = 0000011, else MEMWRITE.
  - MEMREAD → MEMWB on mem_ready.
  - MEMWRITE → FETCH on mem_ready.
  - ALUWB, MEMWB, BRANCH, JAL and JALR → FETCH.
- retire is 1 for the single cycle in which the FSM leaves ALUWB, MEMWB, BRANCH, JAL or JALR, or leaves MEMWRITE with mem_ready = 1.
- Wait counter:
  - Clears on entry to any memory state and increments each cycle the FSM stays in it.
  - When TIMEOUT ≠ 0 and the counter reaches TIMEOUT with mem_ready still 0, the next state is TRAP and trap = 1.
  - mem_ready arriving in that same cycle wins: the FSM proceeds normally and does not trap.
- Latency with MEM_HANDSHAKE = 0: R/I-type and LUI 4 cycles, load 5, store 4, branch 3, JAL/JALR 3.
- opcode is sampled only in DECODE and MEMADR. Its value in any other state is don't-care.
- reset asserted mid-instruction returns the FSM to FETCH immediately. No partial-write protection is provided.

Decomposition:
- Package ctrl_pkg holds:
  - the state_t enum (4-bit encodings FETCH = 0 … TRAP = 13);
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI);
  - encodings for ALUOp, ALUSrcA, ALUSrcB and PCSource.
- One natural sub-module, ctrl_wait_timer, holds the wait counter and timeout compare: inputs clear/enable/mem_ready, output expired.

Test Plan:
1. MEM_HANDSHAKE = 0, opcode 0110011 → states FETCH, DECODE, EXEC_R, ALUWB. Control words match the encodings above; retire pulses once, in cycle 4.
2. Load 0000011 with mem_ready low for 3 cycles in MEMREAD → MEMREAD held for 4 cycles, lorD and MemRead stay high, then MEMWB with RegWrite = 1 and MemtoReg = 1.
3. mem_ready low in FETCH for 2 cycles → PCWrite and IRWrite stay 0 until the mem_ready cycle, then pulse for exactly 1 cycle.
4. TIMEOUT = 4, store with mem_ready held 0 → TRAP after 4 wait cycles, trap = 1 and sticky. Asserting reset = 0 returns to FETCH with trap = 0.
5. Opcode 1111111 in DECODE → TRAP next cycle, all controls 0, retire never pulses.
6. JAL 1101111 → PCWrite = 1, PCSource = 10, RegWrite = 1 in cycle 3, then back to FETCH. Asserting reset mid-DECODE forces FETCH asynchronously, before the next clock edge.
